ddr_req_arbiter: RTL and testbench

Round-robin arbiter that sits directly upstream of the DDR DMA issue stage. It merges read and write requests from up to NUM_REQ compute-side ports (factor-matrix fetchers, result writer) into the single scheduler-side memory interface. It throttles reads against the issue stage's 16-deep return FIFO, and routes in-order read returns back to the originating port by tag. Single clock domain (clk).

---
 rtl/ddr_arb_pkg.sv | 25 ++
 rtl/ddr_arb_tag_fifo.sv | 81 ++++++++
 rtl/ddr_req_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_ddr_req_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_arb_pkg.sv
`default_nettype none
//============================================================================
// Module      : ddr_arb_pkg
// Description : Shared defaults and types for the DDR request arbiter slice.
//               Provides address/data width defaults, the read-in-flight
//               limit, and the tag type used to route read returns.
//               Optional feature macro: DDR_REQ_ARBITER_PERF_EN (used by the
//               top level only).
// Revision    : 1.0 - initial release
//============================================================================
package ddr_arb_pkg;

    localparam int LEN_ADDR_DEF        = 32;
    localparam int LEN_DATA_DEF        = 512;
    localparam int MAX_OUTSTANDING_DEF = 14;

    // Tags are sized for the largest supported port count so that one FIFO
    // type serves every configuration; narrower indices are zero-extended.
    localparam int NUM_REQ_MAX = 8;
    localparam int TAG_W       = $clog2(NUM_REQ_MAX);

    typedef logic [TAG_W-1:0] tag_t;

endpackage : ddr_arb_pkg
`default_nettype wire

// File: rtl/ddr_arb_tag_fifo.sv
`default_nettype none
//============================================================================
// Module      : ddr_arb_tag_fifo
// Description : Synchronous first-word-fall-through FIFO holding the port
//               index of every read in flight, in issue order.
// Ports       : clk, rst (sync, active-low)
//               push_i/push_tag_i : enqueue a tag (ignored when full)
//               pop_i             : dequeue the head (ignored when empty)
//               head_o            : current head tag (valid when !empty_o)
//               full_o / empty_o  : occupancy flags
// Revision    : 1.0 - initial release
//============================================================================
module ddr_arb_tag_fifo
    import ddr_arb_pkg::*;
#(
    parameter int DEPTH = MAX_OUTSTANDING_DEF + 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  tag_t push_tag_i,
    input  logic pop_i,
    output tag_t head_o,
    output logic full_o,
    output logic empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    tag_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i  & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Depth need not be a power of two, so pointers wrap explicitly.
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only read while count_q > 0.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_tag_i;
        end
    end

endmodule : ddr_arb_tag_fifo
`default_nettype wire

// File: rtl/ddr_req_arbiter.sv
`default_nettype none
//============================================================================
// Module      : ddr_req_arbiter
// Description : Round-robin merge of NUM_REQ read/write requesters onto the
//               DDR DMA issue stage. Reads are throttled to MAX_OUTSTANDING
//               in flight; in-order read returns are routed back by tag.
// Ports       : clk, rst (sync, active-low)
//               req_*      : per-port request (valid/we/addr/wdata), req_ready
//               rsp_*      : one-hot return strobe and shared return data
//               mem_out_*  : registered beat toward the issue stage, plus the
//                            return-FIFO pop strobe
//               mem_in_*   : issue-stage accept, return FIFO head/non-empty
//               outstanding: read beats in flight
// Options     : DDR_REQ_ARBITER_PERF_EN adds perf_rd_cnt, perf_wr_cnt and
//               perf_stall_cnt (32-bit wrapping counters).
// Revision    : 1.0 - initial release
//============================================================================
module ddr_req_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int LEN_ADDR        = LEN_ADDR_DEF,
    parameter int LEN_DATA        = LEN_DATA_DEF,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_REQ-1:0]                     req_valid,
    input  logic [NUM_REQ-1:0]                     req_we,
    input  logic [NUM_REQ*LEN_ADDR-1:0]            req_addr,
    input  logic [NUM_REQ*LEN_DATA-1:0]            req_wdata,
    output logic [NUM_REQ-1:0]                     req_ready,
    output logic [NUM_REQ-1:0]                     rsp_valid,
    output logic [LEN_DATA-1:0]                    rsp_data,
    output logic [LEN_ADDR-1:0]                    mem_out_addr,
    output logic [LEN_DATA-1:0]                    mem_out_data,
    output logic                                   mem_out_wrt_enbl,
    output logic                                   mem_out_available,
    output logic                                   mem_out_burst_done,
    output logic                                   mem_out_receive_enbl,
    input  logic                                   mem_in_ready_to_receive,
    input  logic                                   mem_in_data_ready,
    input  logic [LEN_DATA-1:0]                    mem_in_data,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding
`ifdef DDR_REQ_ARBITER_PERF_EN
    ,
    output logic [31:0]                            perf_rd_cnt,
    output logic [31:0]                            perf_wr_cnt,
    output logic [31:0]                            perf_stall_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    outstanding_q, outstanding_d;
    logic [LEN_ADDR-1:0] addr_q, addr_d;
    logic [LEN_DATA-1:0] data_q, data_d;
    logic                we_q, we_d;
    logic                avail_q, avail_d;

    logic                load_ok;
    logic                rd_ok;
    logic [NUM_REQ-1:0]  elig;
    logic                grant_any;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_we;
    logic                rd_grant;
    logic                pop;
    logic                ret_hit;
    logic                tag_full;
    logic                tag_empty;
    tag_t                tag_head;

    // The beat register may be refilled when empty or being consumed now.
    assign load_ok = ~avail_q | mem_in_ready_to_receive;

    // outstanding_q already includes reads granted but not yet accepted
    // downstream, so the throttle covers beats still sitting in addr_q.
    assign rd_ok = (outstanding_q < CNT_W'(MAX_OUTSTANDING));

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = rst & req_valid[i] & (req_we[i] | rd_ok) & ~tag_full;
        end
    end

    // Search from rr_ptr_q upward, wrapping, for the first eligible port.
    always_comb begin
        logic [IDX_W:0]   idx;
        logic [IDX_W-1:0] idx_n;
        logic             found;
        idx       = '0;
        idx_n     = '0;
        found     = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (idx >= (IDX_W+1)'(NUM_REQ)) begin
                idx = idx - (IDX_W+1)'(NUM_REQ);
            end
            idx_n = idx[IDX_W-1:0];
            if (!found && elig[idx_n]) begin
                found     = 1'b1;
                grant_idx = idx_n;
            end
        end
        grant_any = found & load_ok;
    end

    assign grant_we = req_we[grant_idx];
    assign rd_grant = grant_any & ~grant_we;

    always_comb begin
        req_ready = '0;
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        addr_d   = addr_q;
        data_d   = data_q;
        we_d     = we_q;
        avail_d  = avail_q;
        if (grant_any) begin
            rr_ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            addr_d   = req_addr[grant_idx*LEN_ADDR +: LEN_ADDR];
            data_d   = req_wdata[grant_idx*LEN_DATA +: LEN_DATA];
            we_d     = grant_we;
            avail_d  = 1'b1;
        end else if (load_ok) begin
            avail_d  = 1'b0;
        end
    end

    // Every beat presented by the return FIFO is popped; it is only routed
    // to a port when a tag exists for it, otherwise it is an orphan and is
    // dropped (e.g. returns for reads discarded by a reset).
    assign pop     = rst & mem_in_data_ready;
    assign ret_hit = pop & ~tag_empty;

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = ret_hit & (tag_head == tag_t'(i));
        end
    end

    assign rsp_data             = ret_hit ? mem_in_data : '0;
    assign mem_out_receive_enbl = pop;

    always_comb begin
        outstanding_d = outstanding_q;
        case ({rd_grant, ret_hit})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = (outstanding_q == '0) ? '0 : outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_q      <= '0;
            outstanding_q <= '0;
            addr_q        <= '0;
            data_q        <= '0;
            we_q          <= 1'b0;
            avail_q       <= 1'b0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            outstanding_q <= outstanding_d;
            addr_q        <= addr_d;
            data_q        <= data_d;
            we_q          <= we_d;
            avail_q       <= avail_d;
        end
    end

    ddr_arb_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING + 2)
    ) u_tag_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (rd_grant),
        .push_tag_i (tag_t'(grant_idx)),
        .pop_i      (pop),
        .head_o     (tag_head),
        .full_o     (tag_full),
        .empty_o    (tag_empty)
    );

    assign mem_out_addr       = addr_q;
    assign mem_out_data       = data_q;
    assign mem_out_wrt_enbl   = we_q;
    assign mem_out_available  = avail_q;
    assign mem_out_burst_done = avail_q & we_q;
    assign outstanding        = outstanding_q;

`ifdef DDR_REQ_ARBITER_PERF_EN
    logic [31:0] perf_rd_q, perf_wr_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_rd_q    <= '0;
            perf_wr_q    <= '0;
            perf_stall_q <= '0;
        end else begin
            if (rd_grant) begin
                perf_rd_q <= perf_rd_q + 1'b1;
            end
            if (grant_any & grant_we) begin
                perf_wr_q <= perf_wr_q + 1'b1;
            end
            if (avail_q & ~mem_in_ready_to_receive) begin
                perf_stall_q <= perf_stall_q + 1'b1;
            end
        end
    end

    assign perf_rd_cnt    = perf_rd_q;
    assign perf_wr_cnt    = perf_wr_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule : ddr_req_arbiter
`default_nettype wire

// File: tb/tb_ddr_req_arbiter.sv
`default_nettype none
//============================================================================
// Module      : tb_ddr_req_arbiter
// Description : Directed self-checking bench for ddr_req_arbiter (4 ports,
//               64-bit data). Inputs change 1 ns after the rising edge and
//               outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
//============================================================================
module tb_ddr_req_arbiter;

    localparam int NR = 4;
    localparam int LA = 32;
    localparam int LD = 64;
    localparam int MO = 14;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid, req_we, req_ready, rsp_valid;
    logic [NR*LA-1:0]  req_addr;
    logic [NR*LD-1:0]  req_wdata;
    logic [LD-1:0]     rsp_data, mem_out_data, mem_in_data;
    logic [LA-1:0]     mem_out_addr;
    logic              mem_out_wrt_enbl, mem_out_available, mem_out_burst_done;
    logic              mem_out_receive_enbl, mem_in_ready_to_receive, mem_in_data_ready;
    logic [3:0]        outstanding;
`ifdef DDR_REQ_ARBITER_PERF_EN
    logic [31:0]       perf_rd_cnt, perf_wr_cnt, perf_stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    logic [LA-1:0] exp_addr [NR];
    logic [LD-1:0] exp_wd   [NR];

    always #5 clk = ~clk;

    ddr_req_arbiter #(
        .NUM_REQ(NR), .LEN_ADDR(LA), .LEN_DATA(LD), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .req_valid               (req_valid),
        .req_we                  (req_we),
        .req_addr                (req_addr),
        .req_wdata               (req_wdata),
        .req_ready               (req_ready),
        .rsp_valid               (rsp_valid),
        .rsp_data                (rsp_data),
        .mem_out_addr            (mem_out_addr),
        .mem_out_data            (mem_out_data),
        .mem_out_wrt_enbl        (mem_out_wrt_enbl),
        .mem_out_available       (mem_out_available),
        .mem_out_burst_done      (mem_out_burst_done),
        .mem_out_receive_enbl    (mem_out_receive_enbl),
        .mem_in_ready_to_receive (mem_in_ready_to_receive),
        .mem_in_data_ready       (mem_in_data_ready),
        .mem_in_data             (mem_in_data),
        .outstanding             (outstanding)
`ifdef DDR_REQ_ARBITER_PERF_EN
        ,
        .perf_rd_cnt             (perf_rd_cnt),
        .perf_wr_cnt             (perf_wr_cnt),
        .perf_stall_cnt          (perf_stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    // The in-flight count must never exceed the limit (a wrap below zero
    // would show up as a large value here).
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            checks++;
            assert (outstanding <= 4'(MO)) else begin
                errors++;
                $error("FAIL outstanding_bound: observed=%0d expected<=%0d", outstanding, MO);
            end
        end
    end

    initial begin
        int g;
        for (int i = 0; i < NR; i++) begin
            exp_addr[i] = 32'h1000 + 32'(i) * 32'h40;
            exp_wd[i]   = 64'hDA7A_0000_0000_0000 | 64'(i);
            req_addr[i*LA +: LA]  = exp_addr[i];
            req_wdata[i*LD +: LD] = exp_wd[i];
        end

        // Reset held with all requests and a return pending.
        rst = 1'b0; req_valid = 4'hF; req_we = 4'hF;
        mem_in_ready_to_receive = 1'b1; mem_in_data_ready = 1'b1;
        mem_in_data = 64'hBAD;
        repeat (3) nxt();
        smp();
        chk("rst_req_ready",  req_ready, 0);
        chk("rst_avail",      mem_out_available, 0);
        chk("rst_addr",       mem_out_addr, 0);
        chk("rst_data",       mem_out_data, 0);
        chk("rst_we",         mem_out_wrt_enbl, 0);
        chk("rst_burst_done", mem_out_burst_done, 0);
        chk("rst_recv",       mem_out_receive_enbl, 0);
        chk("rst_rsp_valid",  rsp_valid, 0);
        chk("rst_outst",      outstanding, 0);
        nxt();

        // Round robin with all four ports writing.
        rst = 1'b1; mem_in_data_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            smp();
            chk("rr_grant", req_ready, 64'(1) << (k % 4));
            if (k > 0) begin
                chk("rr_addr", mem_out_addr, exp_addr[(k-1) % 4]);
                chk("rr_burst_done", mem_out_burst_done, 1);
            end
            nxt();
        end
        req_valid = 4'h0;
        smp();
        chk("rr_last_addr", mem_out_addr, exp_addr[3]);
        chk("rr_last_data", mem_out_data, exp_wd[3]);
        nxt();

        // Read throttle: port 1 streams reads with returns withheld.
        req_valid = 4'b0010; req_we = 4'b0000;
        g = 0;
        for (int k = 0; k < 20; k++) begin
            smp();
            if (req_ready[1]) g++;
            nxt();
        end
        chk("thr_grants", g, MO);
        smp();
        chk("thr_outst", outstanding, MO);
        chk("thr_blocked", req_ready, 0);
        nxt();
        req_valid = 4'b0110; req_we = 4'b0100;
        smp();
        chk("thr_write_ok", req_ready, 4'b0100);
        nxt();
        req_valid = 4'b0010; req_we = 4'b0000;
        mem_in_data_ready = 1'b1; mem_in_data = 64'hD1;
        smp();
        chk("thr_ret_valid", rsp_valid, 4'b0010);
        chk("thr_ret_data",  rsp_data, 64'hD1);
        chk("thr_ret_recv",  mem_out_receive_enbl, 1);
        chk("thr_ret_nogrant", req_ready, 0);
        nxt();
        mem_in_data_ready = 1'b0;
        smp();
        chk("thr_outst_13", outstanding, MO - 1);
        chk("thr_regrant", req_ready, 4'b0010);
        nxt();
        req_valid = 4'b0000;
        smp();
        chk("thr_outst_full", outstanding, MO);
        nxt();
        mem_in_data_ready = 1'b1;
        for (int k = 0; k < MO; k++) begin
            mem_in_data = 64'h100 + 64'(k);
            smp();
            chk("drain_valid", rsp_valid, 4'b0010);
            chk("drain_data",  rsp_data, 64'h100 + 64'(k));
            nxt();
        end
        mem_in_data_ready = 1'b0;
        smp();
        chk("drain_outst", outstanding, 0);
        nxt();

        // Tag routing: reads from ports 3, 0, 3.
        req_valid = 4'b1000;
        smp(); chk("tag_grant3a", req_ready, 4'b1000); nxt();
        req_valid = 4'b0001;
        smp(); chk("tag_grant0", req_ready, 4'b0001); nxt();
        req_valid = 4'b1000;
        smp(); chk("tag_grant3b", req_ready, 4'b1000); nxt();
        req_valid = 4'b0000;
        mem_in_data_ready = 1'b1; mem_in_data = 64'hAAAA;
        smp(); chk("tag_rsp_a", rsp_valid, 4'b1000); chk("tag_data_a", rsp_data, 64'hAAAA); nxt();
        mem_in_data = 64'hBBBB;
        smp(); chk("tag_rsp_b", rsp_valid, 4'b0001); chk("tag_data_b", rsp_data, 64'hBBBB); nxt();
        mem_in_data = 64'hCCCC;
        smp(); chk("tag_rsp_c", rsp_valid, 4'b1000); chk("tag_data_c", rsp_data, 64'hCCCC); nxt();
        mem_in_data_ready = 1'b0;
        smp(); chk("tag_outst", outstanding, 0); nxt();

        // Backpressure with a write from port 2 pending.
        req_valid = 4'b0001; req_we = 4'b0001;
        smp(); chk("bp_grant0", req_ready, 4'b0001); nxt();
        req_valid = 4'b0100; req_we = 4'b0100; mem_in_ready_to_receive = 1'b0;
        for (int k = 0; k < 5; k++) begin
            smp();
            chk("bp_nogrant", req_ready, 0);
            chk("bp_addr",  mem_out_addr, exp_addr[0]);
            chk("bp_data",  mem_out_data, exp_wd[0]);
            chk("bp_we",    mem_out_wrt_enbl, 1);
            chk("bp_avail", mem_out_available, 1);
            nxt();
        end
        mem_in_ready_to_receive = 1'b1;
        smp(); chk("bp_release_grant", req_ready, 4'b0100);
        nxt();
        req_valid = 4'b0000;
        smp();
        chk("bp_next_addr", mem_out_addr, exp_addr[2]);
        chk("bp_next_data", mem_out_data, exp_wd[2]);
        nxt();

        // Simultaneous read grant and return at outstanding = 7.
        req_valid = 4'b0010; req_we = 4'b0000;
        for (int k = 0; k < 7; k++) begin
            smp();
            nxt();
        end
        mem_in_data_ready = 1'b1; mem_in_data = 64'hEEEE;
        smp();
        chk("sim_outst_pre", outstanding, 7);
        chk("sim_grant", req_ready, 4'b0010);
        chk("sim_rsp", rsp_valid, 4'b0010);
        nxt();
        req_valid = 4'b0000; mem_in_data_ready = 1'b0;
        smp();
        chk("sim_outst_post", outstanding, 7);
        nxt();

        // Mid-run reset discards tags; the next return is an orphan.
        rst = 1'b0;
        nxt();
        rst = 1'b1;
        smp();
        chk("mrst_outst", outstanding, 0);
        chk("mrst_avail", mem_out_available, 0);
        nxt();
        mem_in_data_ready = 1'b1; mem_in_data = 64'hF0F0;
        smp();
        chk("orphan_recv", mem_out_receive_enbl, 1);
        chk("orphan_rsp", rsp_valid, 0);
        nxt();
        mem_in_data_ready = 1'b0;
        smp();
        chk("orphan_outst", outstanding, 0);
        nxt();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ddr_req_arbiter
`default_nettype wire
